// File: rtl/debug_uart_tx.sv
// Debug-port UART transmitter: snapshots seven 8-bit ports on start and sends
// them as one 8N1 frame (sync, seven data bytes, additive checksum).
module debug_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  // state     | meaning
  // IDLE      | line high, waiting for start
  // START_BIT | driving the start bit (0) of the current byte
  // DATA_BITS | driving data bits LSB first
  // STOP_BIT  | driving the stop bit (1); last byte returns to IDLE
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  localparam int          TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LOAD = TW'(CLKS_PER_BIT - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      snap_q [7];
  logic [7:0]      snap_d [7];
  logic [7:0]      csum_q, csum_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      cur_byte;
  logic [7:0]      port_sum;
  logic            timer_last;

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  assign timer_last = (timer_q == '0);
  assign port_sum   = debug_port1 + debug_port2 + debug_port3 + debug_port4 +
                      debug_port5 + debug_port6 + debug_port7;

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap_q[0];
      4'd2:    cur_byte = snap_q[1];
      4'd3:    cur_byte = snap_q[2];
      4'd4:    cur_byte = snap_q[3];
      4'd5:    cur_byte = snap_q[4];
      4'd6:    cur_byte = snap_q[5];
      4'd7:    cur_byte = snap_q[6];
      default: cur_byte = csum_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    csum_d     = csum_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          snap_d[0]  = debug_port1;
          snap_d[1]  = debug_port2;
          snap_d[2]  = debug_port3;
          snap_d[3]  = debug_port4;
          snap_d[4]  = debug_port5;
          snap_d[5]  = debug_port6;
          snap_d[6]  = debug_port7;
          csum_d     = port_sum;
          byte_idx_d = 4'd0;
          bit_idx_d  = 3'd0;
          timer_d    = LOAD;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = START_BIT;
        end
      end

      START_BIT: begin
        if (timer_last) begin
          timer_d   = LOAD;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = DATA_BITS;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      DATA_BITS: begin
        if (timer_last) begin
          timer_d = LOAD;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      STOP_BIT: begin
        if (timer_last) begin
          if (byte_idx_q != 4'd8) begin
            byte_idx_d = byte_idx_q + 4'd1;
            timer_d    = LOAD;
            tx_d       = 1'b0;
            state_d    = START_BIT;
          end else begin
            // Frame complete; start is re-sampled in this same IDLE cycle.
            byte_idx_d = 4'd0;
            bit_idx_d  = 3'd0;
            timer_d    = '0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      csum_q     <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Snapshot contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: per-cycle line model from byte list, UART decode,
// busy/frame_done timing, snapshot isolation, back-to-back and reset cases.
module tb_debug_uart_tx;

  localparam int CPB   = 4;
  localparam int FBITS = 90;
  localparam int FCYC  = FBITS * CPB;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start;
  logic [7:0] port [7];
  logic       tx, busy, frame_done;

  int errs   = 0;
  int checks = 0;

  logic [7:0] exp_b [9];
  logic       exp_tx [FCYC];
  logic       act [FCYC];

  always #5 clk = ~clk;

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .debug_port1(port[0]),
    .debug_port2(port[1]),
    .debug_port3(port[2]),
    .debug_port4(port[3]),
    .debug_port5(port[4]),
    .debug_port6(port[5]),
    .debug_port7(port[6]),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: frame = sync, ports, sum mod 256; each byte 0,d0..d7,1; each bit CPB cycles.
  task automatic build_model();
    int sum = 0;
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      exp_b[i+1] = port[i];
      sum += int'(port[i]);
    end
    exp_b[8] = 8'(sum % 256);
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 10; j++)
        for (int r = 0; r < CPB; r++)
          exp_tx[(k*10 + j)*CPB + r] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[k][j-1];
  endtask

  task automatic set_ports(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 7; i++) port[i] = base + step * 8'(i);
  endtask

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic kick(input bit hold);
    build_model();
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Samples FCYC busy cycles, then checks the frame_done cycle at the final negedge.
  task automatic capture_frame(input string tag, input int poke);
    int wave_err = 0;
    int busy_n   = 0;
    int fd_n     = 0;
    logic [7:0] got;
    for (int i = 0; i < FCYC; i++) begin
      act[i] = tx;
      if (tx !== exp_tx[i]) wave_err++;
      if (busy === 1'b1) busy_n++;
      if (frame_done === 1'b1) fd_n++;
      if (i == poke) start = 1'b1;
      if (i == poke + 1) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, ".tx_wave_errs"}, wave_err, 0);
    chk({tag, ".busy_len"}, busy_n, FCYC);
    chk({tag, ".fd_early"}, fd_n, 0);
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 8; j++) got[j] = act[(k*10 + 1 + j)*CPB + CPB/2];
      chk($sformatf("%s.byte%0d", tag, k), got, exp_b[k]);
      chk($sformatf("%s.framing%0d", tag, k),
          {act[k*10*CPB + CPB/2], act[(k*10 + 9)*CPB + CPB/2]}, 2'b01);
    end
    chk({tag, ".fd_pulse"}, frame_done, 1);
    chk({tag, ".busy_fall"}, busy, 0);
    chk({tag, ".tx_end"}, tx, 1);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    chk({tag, ".idle_bad_cycles"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    start  = 1'b0;
    set_ports(8'h00, 8'h00);

    // 1. reset values
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.tx", i), tx, 1);
      chk($sformatf("rst%0d.busy", i), busy, 0);
      chk($sformatf("rst%0d.fd", i), frame_done, 0);
    end
    nreset = 1'b1;
    idle_check("post_rst", 20);

    // 2. basic frame 01..07 -> checksum 1C
    set_ports(8'h01, 8'h01);
    kick(1'b0);
    chk("basic.cksum_model", exp_b[8], 8'h1C);
    capture_frame("basic", -10);
    idle_check("basic", 5);

    // 3. snapshot isolation, start during busy ignored
    set_ports(8'h10, 8'h10);
    kick(1'b0);
    set_ports(8'h00, 8'h00);
    capture_frame("snap", 100);
    idle_check("snap_no_second", 30);

    // 4. checksum wrap: 7*FF = 1785 -> F9
    set_ports(8'hFF, 8'h00);
    kick(1'b0);
    capture_frame("wrap", -10);
    idle_check("wrap", 5);

    // 5. back-to-back with start held high
    set_ports(8'h01, 8'h01);
    kick(1'b1);
    capture_frame("b2b_1", -10);
    @(negedge clk);
    capture_frame("b2b_2", -10);
    start = 1'b0;
    idle_check("b2b", 10);

    // 6. reset mid-frame (during byte 3), then a clean frame
    set_ports(8'h3C, 8'h11);
    kick(1'b0);
    for (int i = 0; i < 3*10*CPB + 10; i++) @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    nreset = 1'b0;
    @(negedge clk);
    chk("midrst.tx", tx, 1);
    chk("midrst.busy", busy, 0);
    chk("midrst.fd", frame_done, 0);
    nreset = 1'b1;
    idle_check("midrst", 10);
    set_ports(8'h21, 8'h07);
    kick(1'b0);
    capture_frame("after_rst", -10);
    idle_check("after_rst", 3);

    // randomized frames
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 7; i++) port[i] = 8'($urandom_range(0, 255));
      kick(1'b0);
      for (int i = 0; i < 7; i++) port[i] = 8'($urandom_range(0, 255));
      capture_frame($sformatf("rnd%0d", n), int'($urandom_range(20, 300)));
      idle_check($sformatf("rnd%0d", n), 2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
